// File: rtl/fa16_bist_pkg.sv
// Shared types and sizing for the fa16 BIST sequencer.
// Used by fa16_bist_ctrl and fa16_bist_result.
package fa16_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_e;

    localparam int unsigned NUM_PATTERNS_DEF = 8;
    localparam int unsigned PF_LAT_DEF       = 1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CNT_W_DEF = clog2_min1(NUM_PATTERNS_DEF + 1);
    localparam int unsigned IDX_W_DEF = clog2_min1(NUM_PATTERNS_DEF);

endpackage

// File: rtl/fa16_bist_result.sv
// Failure accumulation: count, first failing index and optional map.
// The map register exists only when FA16_BIST_FAILMAP_EN is defined.
module fa16_bist_result
    import fa16_bist_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = NUM_PATTERNS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned IDX_W        = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    smp_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic                    pf_i,
    output logic [CNT_W-1:0]        fail_cnt_o,
    output logic [IDX_W-1:0]        first_fail_o,
    output logic                    first_fail_vld_o,
    output logic [NUM_PATTERNS-1:0] fail_map_o,
    output logic                    cnt_zero_nxt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PATTERNS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             hit;

    assign hit = smp_i && !pf_i;

    always_comb begin
        cnt_d = cnt_q;
        ff_d  = ff_q;
        ffv_d = ffv_q;
        if (clr_i) begin
            cnt_d = '0;
            ff_d  = '0;
            ffv_d = 1'b0;
        end else if (hit) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!ffv_q) begin
                ff_d  = idx_i;
                ffv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ff_q  <= '0;
            ffv_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ff_q  <= ff_d;
            ffv_q <= ffv_d;
        end
    end

    assign fail_cnt_o       = cnt_q;
    assign first_fail_o     = ff_q;
    assign first_fail_vld_o = ffv_q;
    // Lets the controller register pass in the same edge as the last update.
    assign cnt_zero_nxt_o   = (cnt_d == '0);

`ifdef FA16_BIST_FAILMAP_EN
    logic [NUM_PATTERNS-1:0] map_q, map_d;

    always_comb begin
        map_d = map_q;
        if (clr_i) begin
            map_d = '0;
        end else if (hit) begin
            map_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    assign fail_map_o = map_q;
`else
    assign fail_map_o = '0;
`endif

endmodule

// File: rtl/fa16_bist_ctrl.sv
// BIST sequencer/collector for the fa16 wrapper: CLEAR, RUN sweep, DONE.
// Optional per-pattern fail map enabled by FA16_BIST_FAILMAP_EN.
module fa16_bist_ctrl
    import fa16_bist_pkg::*;
#(
    parameter  int unsigned NUM_PATTERNS = NUM_PATTERNS_DEF,
    parameter  int unsigned PF_LAT       = PF_LAT_DEF,
    localparam int unsigned CNT_W        = clog2_min1(NUM_PATTERNS + 1),
    localparam int unsigned IDX_W        = clog2_min1(NUM_PATTERNS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    pf,
    output logic                    dut_en,
    output logic                    dut_rst,
    output logic                    test,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        fail_cnt,
    output logic [IDX_W-1:0]        first_fail,
    output logic                    first_fail_vld,
    output logic [NUM_PATTERNS-1:0] fail_map
);

    localparam int unsigned RUN_LEN = PF_LAT + NUM_PATTERNS;
    localparam int unsigned CYC_W   = clog2_min1(RUN_LEN);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_LEN - 1);
    localparam logic [CYC_W-1:0] CYC_LAT  = CYC_W'(PF_LAT);

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic dut_en_q, dut_en_d;
    logic dut_rst_q, dut_rst_d;
    logic test_q, test_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic pass_q, pass_d;

    logic             smp;
    logic             clr;
    logic             cnt_zero_nxt;
    logic [IDX_W-1:0] idx;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cyc_d   = '0;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign smp = (state_q == S_RUN) && !abort && (cyc_q >= CYC_LAT);
    assign idx = IDX_W'(cyc_q - CYC_LAT);
    // Results are zero whenever the next state is IDLE or CLEAR.
    assign clr = (state_d == S_IDLE) || (state_d == S_CLEAR);

    always_comb begin
        dut_en_d  = 1'b0;
        dut_rst_d = 1'b0;
        test_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        unique case (state_d)
            S_CLEAR: begin
                dut_en_d  = 1'b1;
                dut_rst_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_RUN: begin
                dut_en_d = 1'b1;
                test_d   = 1'b1;
                busy_d   = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = cnt_zero_nxt;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            dut_en_q  <= 1'b0;
            dut_rst_q <= 1'b0;
            test_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            dut_en_q  <= dut_en_d;
            dut_rst_q <= dut_rst_d;
            test_q    <= test_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    fa16_bist_result #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .CNT_W        (CNT_W),
        .IDX_W        (IDX_W)
    ) u_result (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr_i            (clr),
        .smp_i            (smp),
        .idx_i            (idx),
        .pf_i             (pf),
        .fail_cnt_o       (fail_cnt),
        .first_fail_o     (first_fail),
        .first_fail_vld_o (first_fail_vld),
        .fail_map_o       (fail_map),
        .cnt_zero_nxt_o   (cnt_zero_nxt)
    );

    assign dut_en  = dut_en_q;
    assign dut_rst = dut_rst_q;
    assign test    = test_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

endmodule
